// File: rtl/rv_pkg.sv
// Shared RV32I pipeline constants: ALU opcodes, operand selects and forwarding selects.
package rv_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  localparam logic [3:0] ALU_ADD    = 4'h0;
  localparam logic [3:0] ALU_SUB    = 4'h1;
  localparam logic [3:0] ALU_AND    = 4'h2;
  localparam logic [3:0] ALU_OR     = 4'h3;
  localparam logic [3:0] ALU_XOR    = 4'h4;
  localparam logic [3:0] ALU_SLT    = 4'h5;
  localparam logic [3:0] ALU_SLTU   = 4'h6;
  localparam logic [3:0] ALU_SLL    = 4'h7;
  localparam logic [3:0] ALU_ADD_PC = 4'h8;
  localparam logic [3:0] ALU_LUI    = 4'h9;
  localparam logic [3:0] ALU_PASS_B = 4'hA;
  localparam logic [3:0] ALU_SRA    = 4'hB;
  localparam logic [3:0] ALU_SRL    = 4'hC;

  localparam logic [1:0] SRC_A_RS1  = 2'b00;
  localparam logic [1:0] SRC_A_PC   = 2'b01;
  localparam logic [1:0] SRC_A_ZERO = 2'b10;

  localparam logic SRC_B_RS2 = 1'b0;
  localparam logic SRC_B_IMM = 1'b1;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_MEM  = 2'b01,
    FWD_WB   = 2'b10
  } fwd_sel_e;

  // A producer can forward only if it writes a real register matching the consumer index.
  function automatic logic fwd_hit(logic wr, logic [REG_AW-1:0] rd, logic [REG_AW-1:0] rs);
    return wr && (rd != '0) && (rd == rs);
  endfunction

endpackage

// File: rtl/forwarding_unit.sv
// Combinational operand-forwarding select: EX/MEM beats MEM/WB, x0 never forwards.
module forwarding_unit
  import rv_pkg::*;
(
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  output fwd_sel_e          fwd_a,
  output fwd_sel_e          fwd_b
);

  always_comb begin
    fwd_a = FWD_NONE;
    if (fwd_hit(mem_reg_write, mem_rd, rs1)) begin
      fwd_a = FWD_MEM;
    end else if (fwd_hit(wb_reg_write, wb_rd, rs1)) begin
      fwd_a = FWD_WB;
    end
  end

  always_comb begin
    fwd_b = FWD_NONE;
    if (fwd_hit(mem_reg_write, mem_rd, rs2)) begin
      fwd_b = FWD_MEM;
    end else if (fwd_hit(wb_reg_write, wb_rd, rs2)) begin
      fwd_b = FWD_WB;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-side operand forwarding, ALU operand muxing and
// load-use hazard detection toward IF/ID.
module id_ex_stage
  import rv_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_rd1,
  input  logic [XLEN-1:0]   id_rd2,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [3:0]        id_alu_control,
  input  logic [1:0]        id_src_a_sel,
  input  logic              id_src_b_sel,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_branch,
  input  logic              id_jump,
  input  logic [1:0]        id_result_src,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [XLEN-1:0]   mem_alu_result,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_result,
  output logic [XLEN-1:0]   ex_src_a,
  output logic [XLEN-1:0]   ex_src_b,
  output logic [3:0]        ex_alu_control,
  output logic [XLEN-1:0]   ex_store_data,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_imm,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_valid,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_branch,
  output logic              ex_jump,
  output logic [1:0]        ex_result_src,
  output logic              load_use_hazard
);

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rd1;
    logic [XLEN-1:0]   rd2;
    logic [XLEN-1:0]   imm;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [3:0]        alu_control;
    logic [1:0]        src_a_sel;
    logic              src_b_sel;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              branch;
    logic              jump;
    logic [1:0]        result_src;
  } id_ex_t;

  id_ex_t   ex_q, ex_d;
  fwd_sel_e fwd_a, fwd_b;
  logic [XLEN-1:0] fwd_a_val, fwd_b_val;

  // Flush yields an all-zero bubble; an invalid decode slot keeps data but drops side effects.
  always_comb begin
    ex_d = ex_q;
    if (flush) begin
      ex_d = '0;
    end else if (!stall) begin
      ex_d.valid       = id_valid;
      ex_d.pc          = id_pc;
      ex_d.rd1         = id_rd1;
      ex_d.rd2         = id_rd2;
      ex_d.imm         = id_imm;
      ex_d.rs1         = id_rs1;
      ex_d.rs2         = id_rs2;
      ex_d.rd          = id_rd;
      ex_d.alu_control = id_alu_control;
      ex_d.src_a_sel   = id_src_a_sel;
      ex_d.src_b_sel   = id_src_b_sel;
      ex_d.result_src  = id_result_src;
      ex_d.reg_write   = id_valid & id_reg_write;
      ex_d.mem_read    = id_valid & id_mem_read;
      ex_d.mem_write   = id_valid & id_mem_write;
      ex_d.branch      = id_valid & id_branch;
      ex_d.jump        = id_valid & id_jump;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  forwarding_unit u_forwarding_unit (
    .rs1           (ex_q.rs1),
    .rs2           (ex_q.rs2),
    .mem_reg_write (mem_reg_write),
    .mem_rd        (mem_rd),
    .wb_reg_write  (wb_reg_write),
    .wb_rd         (wb_rd),
    .fwd_a         (fwd_a),
    .fwd_b         (fwd_b)
  );

  always_comb begin
    unique case (fwd_a)
      FWD_MEM: fwd_a_val = mem_alu_result;
      FWD_WB:  fwd_a_val = wb_result;
      default: fwd_a_val = ex_q.rd1;
    endcase
  end

  always_comb begin
    unique case (fwd_b)
      FWD_MEM: fwd_b_val = mem_alu_result;
      FWD_WB:  fwd_b_val = wb_result;
      default: fwd_b_val = ex_q.rd2;
    endcase
  end

  // The reserved select encoding behaves like SRC_A_ZERO.
  always_comb begin
    case (ex_q.src_a_sel)
      SRC_A_RS1: ex_src_a = fwd_a_val;
      SRC_A_PC:  ex_src_a = ex_q.pc;
      default:   ex_src_a = '0;
    endcase
  end

  assign ex_src_b       = (ex_q.src_b_sel == SRC_B_IMM) ? ex_q.imm : fwd_b_val;
  assign ex_store_data  = fwd_b_val;
  assign ex_alu_control = ex_q.alu_control;
  assign ex_pc          = ex_q.pc;
  assign ex_imm         = ex_q.imm;
  assign ex_rd          = ex_q.rd;
  assign ex_valid       = ex_q.valid;
  assign ex_reg_write   = ex_q.reg_write;
  assign ex_mem_read    = ex_q.mem_read;
  assign ex_mem_write   = ex_q.mem_write;
  assign ex_branch      = ex_q.branch;
  assign ex_jump        = ex_q.jump;
  assign ex_result_src  = ex_q.result_src;

  assign load_use_hazard = ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) &&
                           ((ex_q.rd == id_rs1) || (ex_q.rd == id_rs2));

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: a behavioural model checked every negedge plus
// hand-computed literal expectations for directed scenarios.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush, id_valid;
  logic [31:0] id_pc, id_rd1, id_rd2, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [3:0]  id_alu_control;
  logic [1:0]  id_src_a_sel;
  logic        id_src_b_sel;
  logic        id_reg_write, id_mem_read, id_mem_write, id_branch, id_jump;
  logic [1:0]  id_result_src;
  logic        mem_reg_write;
  logic [4:0]  mem_rd;
  logic [31:0] mem_alu_result;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_result;
  logic [31:0] ex_src_a, ex_src_b, ex_store_data, ex_pc, ex_imm;
  logic [3:0]  ex_alu_control;
  logic [4:0]  ex_rd;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump;
  logic [1:0]  ex_result_src;
  logic        load_use_hazard;

  int errors = 0;
  int checks = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_pc(id_pc), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_control(id_alu_control),
    .id_src_a_sel(id_src_a_sel), .id_src_b_sel(id_src_b_sel),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_branch(id_branch), .id_jump(id_jump), .id_result_src(id_result_src),
    .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_alu_result(mem_alu_result),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
    .ex_src_a(ex_src_a), .ex_src_b(ex_src_b), .ex_alu_control(ex_alu_control),
    .ex_store_data(ex_store_data), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rd(ex_rd),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_branch(ex_branch), .ex_jump(ex_jump),
    .ex_result_src(ex_result_src), .load_use_hazard(load_use_hazard)
  );

  // Model state: the instruction currently held in EX, as the spec describes it.
  typedef struct packed {
    logic        valid;
    logic [31:0] pc, rd1, rd2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  alu;
    logic [1:0]  a_sel;
    logic        b_sel;
    logic        rw, mr, mw, br, jp;
    logic [1:0]  rsrc;
  } m_t;

  m_t m;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m <= '0;
    end else if (flush) begin
      m <= '0;
    end else if (!stall) begin
      m <= '{valid: id_valid, pc: id_pc, rd1: id_rd1, rd2: id_rd2, imm: id_imm,
             rs1: id_rs1, rs2: id_rs2, rd: id_rd, alu: id_alu_control,
             a_sel: id_src_a_sel, b_sel: id_src_b_sel,
             rw: id_valid && id_reg_write, mr: id_valid && id_mem_read,
             mw: id_valid && id_mem_write, br: id_valid && id_branch,
             jp: id_valid && id_jump, rsrc: id_result_src};
    end
  end

  function automatic logic [31:0] operand(input logic [4:0] rs, input logic [31:0] regv);
    if (rs != 0 && mem_reg_write && mem_rd == rs) return mem_alu_result;
    if (rs != 0 && wb_reg_write && wb_rd == rs) return wb_result;
    return regv;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  logic [31:0] e_a, e_b;
  always @(negedge clk) begin
    if (chk_en) begin
      e_a = (m.a_sel == 2'b00) ? operand(m.rs1, m.rd1) : (m.a_sel == 2'b01) ? m.pc : 32'h0;
      e_b = m.b_sel ? m.imm : operand(m.rs2, m.rd2);
      chk("model src_a", ex_src_a, e_a);
      chk("model src_b", ex_src_b, e_b);
      chk("model store_data", ex_store_data, operand(m.rs2, m.rd2));
      chk("model alu_control", {28'h0, ex_alu_control}, {28'h0, m.alu});
      chk("model pc", ex_pc, m.pc);
      chk("model imm", ex_imm, m.imm);
      chk("model rd", {27'h0, ex_rd}, {27'h0, m.rd});
      chk("model ctrl",
          {24'h0, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump,
           ex_result_src},
          {24'h0, m.valid, m.rw, m.mr, m.mw, m.br, m.jp, m.rsrc});
      chk("model hazard", {31'h0, load_use_hazard},
          {31'h0, m.valid && m.mr && m.rd != 0 && (m.rd == id_rs1 || m.rd == id_rs2)});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_id();
    id_valid = 0; id_pc = 0; id_rd1 = 0; id_rd2 = 0; id_imm = 0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_alu_control = 0;
    id_src_a_sel = 0; id_src_b_sel = 0;
    id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; id_branch = 0; id_jump = 0;
    id_result_src = 0;
  endtask

  initial begin
    rst_n = 0; stall = 0; flush = 0;
    clear_id();
    mem_reg_write = 0; mem_rd = 0; mem_alu_result = 0;
    wb_reg_write = 0; wb_rd = 0; wb_result = 0;
    step(); step();
    rst_n = 1;
    chk_en = 1;

    // Reset asserted mid-cycle clears everything before the next edge.
    id_valid = 1; id_reg_write = 1; id_alu_control = 4'h3; id_pc = 32'h40; id_rd = 5'd6;
    step();
    chk("pre-reset valid", {31'h0, ex_valid}, 32'h1);
    #2 rst_n = 0;
    #1;
    chk("reset valid", {31'h0, ex_valid}, 32'h0);
    chk("reset reg_write", {31'h0, ex_reg_write}, 32'h0);
    chk("reset alu_control", {28'h0, ex_alu_control}, 32'h0);
    #2 rst_n = 1;

    // Plain capture through the immediate path.
    clear_id();
    id_valid = 1; id_rd1 = 5; id_imm = 7; id_src_b_sel = 1; id_rs1 = 1; id_rs2 = 2;
    id_alu_control = 4'h0; id_rd = 5'd8; id_reg_write = 1;
    step();
    chk("capture src_a", ex_src_a, 32'd5);
    chk("capture src_b", ex_src_b, 32'd7);

    // Double forward: EX/MEM wins, then MEM/WB, then x0 never forwards.
    clear_id();
    id_valid = 1; id_rs1 = 3; id_rs2 = 3; id_rd1 = 32'h11; id_rd2 = 32'h12;
    mem_reg_write = 1; mem_rd = 3; mem_alu_result = 32'hAA;
    wb_reg_write = 1; wb_rd = 3; wb_result = 32'hBB;
    step();
    chk("fwd mem src_a", ex_src_a, 32'hAA);
    chk("fwd mem src_b", ex_src_b, 32'hAA);
    mem_reg_write = 0;
    #1;
    chk("fwd wb src_a", ex_src_a, 32'hBB);
    chk("fwd wb store", ex_store_data, 32'hBB);
    mem_reg_write = 1; mem_rd = 0; wb_rd = 0;
    id_rs1 = 0; id_rs2 = 0; id_rd1 = 32'h22;
    step();
    chk("x0 no fwd", ex_src_a, 32'h22);
    mem_rd = 3; wb_rd = 3;

    // Stall holds for two cycles, then stall+flush gives a bubble.
    clear_id();
    id_valid = 1; id_pc = 32'h200; id_rd = 5'd7; id_reg_write = 1; id_branch = 1;
    step();
    stall = 1; id_pc = 32'h300; id_rd = 5'd9;
    step(); step();
    chk("stall pc", ex_pc, 32'h200);
    chk("stall rd", {27'h0, ex_rd}, 32'd7);
    flush = 1;
    step();
    chk("flush valid", {31'h0, ex_valid}, 32'h0);
    chk("flush reg_write", {31'h0, ex_reg_write}, 32'h0);
    chk("flush pc", ex_pc, 32'h0);
    stall = 0; flush = 0;

    // Load-use hazard and its suppressed variants.
    clear_id();
    id_valid = 1; id_mem_read = 1; id_reg_write = 1; id_rd = 5'd4; id_rs1 = 1; id_rs2 = 2;
    step();
    id_rs1 = 9; id_rs2 = 4;
    #1;
    chk("load-use hit", {31'h0, load_use_hazard}, 32'h1);
    id_rd = 5'd0;
    step();
    id_rs1 = 0; id_rs2 = 0;
    #1;
    chk("load-use rd0", {31'h0, load_use_hazard}, 32'h0);
    id_valid = 0; id_rd = 5'd4;
    step();
    id_rs2 = 4;
    #1;
    chk("load-use invalid", {31'h0, load_use_hazard}, 32'h0);
    chk("invalid mem_read", {31'h0, ex_mem_read}, 32'h0);

    // AUIPC operands, then zero/reserved A selects.
    clear_id();
    id_valid = 1; id_src_a_sel = 2'b01; id_pc = 32'h100; id_imm = 32'h12345000;
    id_src_b_sel = 1; id_alu_control = 4'h8; id_rd = 5'd10; id_reg_write = 1;
    step();
    chk("auipc src_a", ex_src_a, 32'h100);
    chk("auipc src_b", ex_src_b, 32'h12345000);
    chk("auipc alu", {28'h0, ex_alu_control}, 32'h8);
    id_src_a_sel = 2'b10; id_rd1 = 32'h55; id_rs1 = 5;
    step();
    chk("zero src_a", ex_src_a, 32'h0);
    id_src_a_sel = 2'b11;
    step();
    chk("reserved src_a", ex_src_a, 32'h0);

    // Store with jump/mem_write and a few mixed vectors for the model check.
    clear_id();
    id_valid = 1; id_mem_write = 1; id_jump = 1; id_result_src = 2'b10;
    id_rs2 = 3; id_rd2 = 32'h77; mem_reg_write = 0; wb_reg_write = 0;
    step();
    chk("store data", ex_store_data, 32'h77);
    for (int i = 0; i < 6; i++) begin
      id_valid = i[0]; id_rs1 = 5'(i); id_rs2 = 5'(i + 1); id_rd1 = 32'(i * 3);
      id_rd2 = 32'(i * 5); id_src_b_sel = i[1]; mem_reg_write = i[2];
      wb_reg_write = 1; wb_rd = 5'(i + 1); wb_result = 32'hC0 + 32'(i);
      step();
    end

    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
